// File: rtl/demux_stream.sv
// demux_stream: routes one input stream into one of two independent 2-entry FIFO channels.
// Each channel keeps registered output data and a modulo-256 count of accepted words.
module demux_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned OW  = 2;

  logic [WIDTH-1:0] mem [NCH][DEPTH];
  logic [NCH-1:0]   rd_ptr;
  logic [NCH-1:0]   wr_ptr;
  logic [OW-1:0]    occ [NCH];
  logic [CW-1:0]    cnt [NCH];

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // Handshake decode; in_ready looks only at the selected channel's fill level.
  always_comb begin
    full     = '0;
    pop      = '0;
    push     = '0;
    for (int i = 0; i < NCH; i++) begin
      full[i] = (occ[i] == OW'(2));
      pop[i]  = (occ[i] != OW'(0)) && out_ready[i];
    end
    in_ready       = !full[in_sel];
    push[in_sel]   = in_valid && in_ready;
  end

  // Storage is not reset; contents are only visible while occupancy is nonzero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < NCH; i++) begin
        occ[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= ~wr_ptr[i];
          cnt[i]    <= cnt[i] + CW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
        case ({push[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + OW'(1);
          2'b01:   occ[i] <= occ[i] - OW'(1);
          default: occ[i] <= occ[i];
        endcase
      end
    end
  end

  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];
  assign out0_valid = (occ[0] != OW'(0));
  assign out1_valid = (occ[1] != OW'(0));
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule
